// File: rtl/motion_arbiter_pkg.sv
// Shared types, requester indices and helpers for the motion arbiter.
// Requester numbering also sets fixed priority: higher index wins.
package motion_arbiter_pkg;

    localparam int REQ_FWD   = 0;
    localparam int REQ_LEFT  = 1;
    localparam int REQ_RIGHT = 2;
    localparam int REQ_REV   = 3;

    localparam logic [3:0] INS_BRAKE = 4'b0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DEADTIME,
        ST_DRIVE,
        ST_FAULT
    } state_t;

    // IN1/IN2 and IN3/IN4 each drive one half-bridge leg pair.
    function automatic logic shoot_through(input logic [3:0] ins);
        return (ins[0] & ins[1]) | (ins[2] & ins[3]);
    endfunction

endpackage

// File: rtl/motion_arbiter_prio_enc.sv
// Fixed-priority 4->one-hot encoder plus "eligible above owner" test.
// Shared by the dead-time exit winner pick and the preemption check.
module motion_prio_enc
    import motion_arbiter_pkg::*;
(
    input  logic [3:0] i_req,
    input  logic [1:0] i_owner,
    output logic [3:0] o_onehot,
    output logic [1:0] o_idx,
    output logic       o_any,
    output logic       o_higher
);

    logic [3:0] w_mask;

    always_comb begin
        o_onehot = 4'b0000;
        o_idx    = 2'd0;
        priority case (1'b1)
            i_req[REQ_REV]: begin
                o_onehot = 4'b1000;
                o_idx    = 2'(REQ_REV);
            end
            i_req[REQ_RIGHT]: begin
                o_onehot = 4'b0100;
                o_idx    = 2'(REQ_RIGHT);
            end
            i_req[REQ_LEFT]: begin
                o_onehot = 4'b0010;
                o_idx    = 2'(REQ_LEFT);
            end
            i_req[REQ_FWD]: begin
                o_onehot = 4'b0001;
                o_idx    = 2'(REQ_FWD);
            end
            default: begin
                o_onehot = 4'b0000;
                o_idx    = 2'd0;
            end
        endcase
    end

    // Bits strictly above the owner; shifts out to zero for rev.
    assign w_mask   = 4'b1110 << i_owner;
    assign o_any    = |i_req;
    assign o_higher = |(i_req & w_mask);

endmodule

// File: rtl/motion_arbiter.sv
// Arbitrates the single H-bridge between fwd/left/right/rev movers,
// with braked dead-time on owner change, IR veto and shoot-through fault.
module motion_arbiter
    import motion_arbiter_pkg::*;
#(
    parameter int DEAD_CYCLES = 200000,
    parameter int CNT_W       = 18
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [15:0] req_ins,
    input  logic        sensorIR_front,
    output logic [3:0]  grant,
    output logic [3:0]  sendToH_BridgeINs,
    output logic        isMoving_out,
    output logic        deadtime_busy,
    output logic        fault
);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_owner;
    logic [3:0]       r_grant;
    logic [3:0]       r_ins;
    logic             r_moving;
    logic             r_busy;
    logic             r_fault;

    logic [3:0] w_elig;
    logic [3:0] w_win_onehot;
    logic [1:0] w_win_idx;
    logic       w_any;
    logic       w_higher;
    logic [3:0] w_own_ins;
    logic [3:0] w_win_ins;
    logic       w_cnt_done;
    logic       w_drop;
    logic       w_ir_veto;
    logic       w_exit;

    assign w_elig = req & ~{3'b000, sensorIR_front};

    motion_prio_enc u_prio (
        .i_req    (w_elig),
        .i_owner  (r_owner),
        .o_onehot (w_win_onehot),
        .o_idx    (w_win_idx),
        .o_any    (w_any),
        .o_higher (w_higher)
    );

    assign w_own_ins  = req_ins[{r_owner, 2'b00} +: 4];
    assign w_win_ins  = req_ins[{w_win_idx, 2'b00} +: 4];
    assign w_cnt_done = (r_cnt == CNT_W'(DEAD_CYCLES - 1));
    assign w_drop     = ~req[r_owner];
    assign w_ir_veto  = (r_owner == 2'(REQ_FWD)) & sensorIR_front;
    assign w_exit     = w_drop | w_higher | w_ir_veto;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_owner  <= 2'd0;
            r_grant  <= 4'b0000;
            r_ins    <= INS_BRAKE;
            r_moving <= 1'b0;
            r_busy   <= 1'b0;
            r_fault  <= 1'b0;
        end else begin
            // Brake unless a branch below keeps the bridge driven.
            r_grant  <= 4'b0000;
            r_ins    <= INS_BRAKE;
            r_moving <= 1'b0;
            r_busy   <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_state <= ST_DEADTIME;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_DEADTIME: begin
                    if (!w_cnt_done) begin
                        r_cnt  <= r_cnt + 1'b1;
                        r_busy <= 1'b1;
                    end else begin
                        r_cnt <= '0;
                        if (!w_any) begin
                            r_state <= ST_IDLE;
                        end else if (shoot_through(w_win_ins)) begin
                            r_state <= ST_FAULT;
                            r_fault <= 1'b1;
                        end else begin
                            r_state  <= ST_DRIVE;
                            r_owner  <= w_win_idx;
                            r_grant  <= w_win_onehot;
                            r_ins    <= w_win_ins;
                            r_moving <= |w_win_ins;
                        end
                    end
                end
                ST_DRIVE: begin
                    if (shoot_through(w_own_ins)) begin
                        r_state <= ST_FAULT;
                        r_fault <= 1'b1;
                    end else if (w_exit) begin
                        r_state <= ST_DEADTIME;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end else begin
                        r_grant  <= r_grant;
                        r_ins    <= w_own_ins;
                        r_moving <= |w_own_ins;
                    end
                end
                ST_FAULT: begin
                    r_fault <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign grant             = r_grant;
    assign sendToH_BridgeINs = r_ins;
    assign isMoving_out      = r_moving;
    assign deadtime_busy     = r_busy;
    assign fault             = r_fault;

endmodule

// File: tb/tb_motion_arbiter.sv
// Directed table, corner sequences and random traffic for motion_arbiter.
module tb_motion_arbiter;

    localparam int DC = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [15:0] req_ins;
    logic        sensorIR_front;
    logic [3:0]  grant;
    logic [3:0]  sendToH_BridgeINs;
    logic        isMoving_out;
    logic        deadtime_busy;
    logic        fault;

    int n_pass  = 0;
    int n_total = 0;

    always #1 clock = ~clock;

    motion_arbiter #(.DEAD_CYCLES(DC), .CNT_W(8)) dut (
        .clock             (clock),
        .reset             (reset),
        .req               (req),
        .req_ins           (req_ins),
        .sensorIR_front    (sensorIR_front),
        .grant             (grant),
        .sendToH_BridgeINs (sendToH_BridgeINs),
        .isMoving_out      (isMoving_out),
        .deadtime_busy     (deadtime_busy),
        .fault             (fault)
    );

    // Reference model: owner (-1 none), remaining brake cycles, fault flag.
    int         m_owner = -1;
    int         m_dead  = 0;
    bit         m_fault = 1'b0;
    logic [3:0] m_ins   = 4'b0000;

    function automatic bit is_bad(input logic [3:0] p);
        return (p[0] && p[1]) || (p[2] && p[3]);
    endfunction

    function automatic int top_elig(input logic [3:0] e);
        for (int i = 3; i >= 0; i--) if (e[i]) return i;
        return -1;
    endfunction

    task automatic model_step(input logic r, input logic [3:0] q,
                              input logic [15:0] ins, input logic ir);
        logic [3:0] elig;
        logic [3:0] p;
        int w;
        elig = q & ~{3'b000, ir};
        if (r) begin
            m_owner = -1; m_dead = 0; m_fault = 0; m_ins = 0;
        end else if (!m_fault) begin
            if (m_owner >= 0) begin
                p = ins[4*m_owner +: 4];
                if (is_bad(p)) begin
                    m_fault = 1; m_owner = -1; m_ins = 0;
                end else if (!q[m_owner] || top_elig(elig) > m_owner
                             || (m_owner == 0 && ir)) begin
                    m_owner = -1; m_dead = DC; m_ins = 0;
                end else begin
                    m_ins = p;
                end
            end else if (m_dead > 0) begin
                m_dead--;
                if (m_dead == 0) begin
                    w = top_elig(elig);
                    if (w >= 0) begin
                        p = ins[4*w +: 4];
                        if (is_bad(p)) m_fault = 1;
                        else begin m_owner = w; m_ins = p; end
                    end
                end
            end else if (elig != 0) begin
                m_dead = DC;
            end
        end
    endtask

    function automatic logic [10:0] pack(input logic [3:0] g, input logic [3:0] p,
                                         input logic b, input logic f, input logic m);
        return {g, p, b, f, m};
    endfunction

    function automatic logic [10:0] dut_vec();
        return pack(grant, sendToH_BridgeINs, deadtime_busy, fault, isMoving_out);
    endfunction

    function automatic logic [10:0] mdl_vec();
        logic [3:0] g;
        g = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
        return pack(g, m_ins, m_dead > 0, m_fault, (m_owner >= 0) && (m_ins != 0));
    endfunction

    task automatic check(input string name, input logic [10:0] got,
                         input logic [10:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got g/ins/b/f/m=%b exp=%b", name, got, exp);
    endtask

    // Drive at negedge, clock once, sample at the following negedge.
    task automatic cyc(input logic r, input logic [3:0] q,
                       input logic [15:0] ins, input logic ir);
        reset = r; req = q; req_ins = ins; sensorIR_front = ir;
        @(posedge clock);
        model_step(r, q, ins, ir);
        @(negedge clock);
    endtask

    typedef struct {
        logic        rst;
        logic [3:0]  q;
        logic [15:0] ins;
        logic        ir;
        logic [10:0] exp;
    } vec_t;

    vec_t tbl[22];

    function automatic vec_t mk(input logic r, input logic [3:0] q,
                                input logic [15:0] ins, input logic ir,
                                input logic [10:0] exp);
        vec_t v;
        v.rst = r; v.q = q; v.ins = ins; v.ir = ir; v.exp = exp;
        return v;
    endfunction

    logic [3:0] pool [9] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h5, 4'h6, 4'h9, 4'hA};

    function automatic logic [3:0] rnib();
        if ($urandom_range(0, 39) == 0) return 4'hC;
        return pool[$urandom_range(0, 8)];
    endfunction

    initial begin
        logic [10:0] BUSY, IDLE0, FLT;
        logic [3:0]  rq;
        logic [15:0] ri;
        BUSY  = pack(4'b0000, 4'b0000, 1, 0, 0);
        IDLE0 = pack(4'b0000, 4'b0000, 0, 0, 0);
        FLT   = pack(4'b0000, 4'b0000, 0, 1, 0);

        tbl[0]  = mk(1, 4'b0000, 16'h0000, 0, IDLE0);
        tbl[1]  = mk(0, 4'b0001, 16'h000A, 0, BUSY);
        tbl[2]  = mk(0, 4'b0001, 16'h000A, 0, BUSY);
        tbl[3]  = mk(0, 4'b0001, 16'h000A, 0, BUSY);
        tbl[4]  = mk(0, 4'b0001, 16'h000A, 0, BUSY);
        tbl[5]  = mk(0, 4'b0001, 16'h000A, 0, pack(4'b0001, 4'b1010, 0, 0, 1));
        tbl[6]  = mk(0, 4'b0001, 16'h000A, 0, pack(4'b0001, 4'b1010, 0, 0, 1));
        tbl[7]  = mk(0, 4'b0001, 16'h000A, 1, BUSY);
        tbl[8]  = mk(0, 4'b0001, 16'h000A, 1, BUSY);
        tbl[9]  = mk(0, 4'b0001, 16'h000A, 0, BUSY);
        tbl[10] = mk(0, 4'b0001, 16'h000A, 0, BUSY);
        tbl[11] = mk(0, 4'b0001, 16'h000A, 0, pack(4'b0001, 4'b1010, 0, 0, 1));
        tbl[12] = mk(0, 4'b1001, 16'h500A, 0, BUSY);
        tbl[13] = mk(0, 4'b1001, 16'h500A, 0, BUSY);
        tbl[14] = mk(0, 4'b1001, 16'h500A, 0, BUSY);
        tbl[15] = mk(0, 4'b1001, 16'h500A, 0, BUSY);
        tbl[16] = mk(0, 4'b1001, 16'h500A, 0, pack(4'b1000, 4'b0101, 0, 0, 1));
        tbl[17] = mk(0, 4'b1011, 16'h503A, 0, pack(4'b1000, 4'b0101, 0, 0, 1));
        tbl[18] = mk(0, 4'b1011, 16'hC03A, 0, FLT);
        tbl[19] = mk(0, 4'b0001, 16'h000A, 0, FLT);
        tbl[20] = mk(1, 4'b0001, 16'h000A, 0, IDLE0);
        tbl[21] = mk(0, 4'b0000, 16'h0000, 0, IDLE0);

        reset = 1; req = 0; req_ins = 0; sensorIR_front = 0;
        @(negedge clock);

        for (int i = 0; i < 22; i++) begin
            cyc(tbl[i].rst, tbl[i].q, tbl[i].ins, tbl[i].ir);
            check($sformatf("tbl%0d", i), dut_vec(), tbl[i].exp);
        end

        // IR stays high through dead-time: fwd is not regranted.
        for (int i = 0; i <= DC; i++) cyc(0, 4'b0001, 16'h0009, 0);
        check("fwd_drive", dut_vec(), pack(4'b0001, 4'b1001, 0, 0, 1));
        for (int i = 0; i < DC; i++) cyc(0, 4'b0001, 16'h0009, 1);
        check("ir_busy", dut_vec(), BUSY);
        cyc(0, 4'b0001, 16'h0009, 1);
        check("ir_to_idle", dut_vec(), IDLE0);
        cyc(0, 4'b0001, 16'h0009, 1);
        check("ir_stay_idle", dut_vec(), IDLE0);

        // Winner picked at exit, not entry.
        cyc(1, 4'b0000, 16'h0000, 0);
        cyc(0, 4'b0110, 16'h0640, 0);
        cyc(0, 4'b0110, 16'h0640, 0);
        cyc(0, 4'b0010, 16'h0640, 0);
        cyc(0, 4'b0010, 16'h0640, 0);
        cyc(0, 4'b0010, 16'h0640, 0);
        check("exit_winner", dut_vec(), pack(4'b0010, 4'b0100, 0, 0, 1));

        // Pattern tracking, then reset while driving.
        cyc(0, 4'b0010, 16'h0620, 0);
        check("track_ins", dut_vec(), pack(4'b0010, 4'b0010, 0, 0, 1));
        cyc(0, 4'b0010, 16'h0600, 0);
        check("drive_zero", dut_vec(), pack(4'b0010, 4'b0000, 0, 0, 0));
        cyc(1, 4'b0010, 16'h0620, 0);
        check("reset_mid_drive", dut_vec(), IDLE0);

        // Random traffic against the model.
        rq = 0; ri = 0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 7) == 0) rq = 4'($urandom);
            if ($urandom_range(0, 3) == 0) ri = {rnib(), rnib(), rnib(), rnib()};
            cyc($urandom_range(0, 59) == 0, rq, ri, $urandom_range(0, 3) == 0);
            check($sformatf("rand%0d", i), dut_vec(), mdl_vec());
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
